// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with registered, write-forwarded reads and a bulk-clear sequencer.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_mp #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 16,
  parameter int NUM_RD    = 4,
  parameter int NUM_WR    = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_RD*AW-1:0]        raddr,
  output logic [NUM_RD*DATAWIDTH-1:0] rdata,
  input  logic [NUM_WR-1:0]           we,
  input  logic [NUM_WR*AW-1:0]        waddr,
  input  logic [NUM_WR*DATAWIDTH-1:0] wdata,
  input  logic                        clr_req,
  output logic                        busy,
  output logic                        clr_done
);
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t               r_state;
  logic [AW-1:0]        r_clr_ptr;
  logic                 r_clr_done;
  logic [DATAWIDTH-1:0] r_mem [DEPTH];
  assign busy     = (r_state == CLEAR);
  assign clr_done = r_clr_done;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state    <= IDLE;
      r_clr_ptr  <= '0;
      r_clr_done <= 1'b0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (r_state == CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
      r_clr_ptr        <= (r_clr_ptr == AW'(DEPTH-1)) ? '0 : r_clr_ptr + 1'b1;
      r_clr_done       <= (r_clr_ptr == AW'(DEPTH-1));
      r_state          <= (r_clr_ptr == AW'(DEPTH-1)) ? IDLE : CLEAR;
    end else begin
      // ascending loop: the highest enabled port index lands last and wins
      for (int j = 0; j < NUM_WR; j++)
        if (we[j] && !(ZERO_REG && waddr[j*AW +: AW] == '0))
          r_mem[waddr[j*AW +: AW]] <= wdata[j*DATAWIDTH +: DATAWIDTH];
      r_clr_done <= 1'b0;
      r_clr_ptr  <= '0;
      r_state    <= clr_req ? CLEAR : IDLE;
    end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]        w_a;
    logic [DATAWIDTH-1:0] w_rd;
    logic [DATAWIDTH-1:0] r_rd;
    assign w_a = raddr[i*AW +: AW];
    always_comb begin
      w_rd = r_mem[w_a];
      if (r_state == CLEAR) w_rd = (w_a == r_clr_ptr) ? '0 : r_mem[w_a];
      else
        for (int j = 0; j < NUM_WR; j++)
          if (we[j] && waddr[j*AW +: AW] == w_a) w_rd = wdata[j*DATAWIDTH +: DATAWIDTH];
      if (ZERO_REG && w_a == '0) w_rd = '0;
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) r_rd <= '0;
      else r_rd <= w_rd;
    assign rdata[i*DATAWIDTH +: DATAWIDTH] = r_rd;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized regfile_mp bench against an array-based reference model.
module tb_regfile_mp;
  localparam int DW = 32, D = 16, NR = 4, NW = 2, AW = 4;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, clr_req = 1'b0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata;
  logic [NW-1:0]    we = '0;
  logic [NW*AW-1:0] waddr = '0;
  logic [NW*DW-1:0] wdata = '0;
  logic busy, clr_done;
  int checks = 0, errors = 0;
  logic [DW-1:0] m [D];
  logic [DW-1:0] exp_rd [NR];
  bit m_busy, m_done;
  int m_ptr;

  regfile_mp #(.DATAWIDTH(DW), .DEPTH(D), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .we(we), .waddr(waddr),
    .wdata(wdata), .clr_req(clr_req), .busy(busy), .clr_done(clr_done));

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < D; k++) m[k] = '0;
    for (int i = 0; i < NR; i++) exp_rd[i] = '0;
    m_busy = 0; m_done = 0; m_ptr = 0;
  endtask

  task automatic tick();
    int a, w;
    for (int i = 0; i < NR; i++) begin
      a = int'(raddr[i*AW +: AW]);
      if (m_busy) exp_rd[i] = (a == m_ptr) ? '0 : m[a];
      else begin
        exp_rd[i] = m[a];
        for (int j = 0; j < NW; j++)
          if (we[j] && int'(waddr[j*AW +: AW]) == a) exp_rd[i] = wdata[j*DW +: DW];
      end
      if (ZR && a == 0) exp_rd[i] = '0;
    end
    if (m_busy) begin
      m[m_ptr] = '0;
      m_done = (m_ptr == D-1);
      m_busy = !m_done;
      m_ptr++;
    end else begin
      for (int j = 0; j < NW; j++) begin
        w = int'(waddr[j*AW +: AW]);
        if (we[j] && !(ZR && w == 0)) m[w] = wdata[j*DW +: DW];
      end
      m_done = 0;
      if (clr_req) begin m_busy = 1; m_ptr = 0; end
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_inputs(input bit allow_clr);
    raddr = NR*AW'($urandom);
    we    = NW'($urandom);
    waddr = NW*AW'($urandom);
    wdata = {$urandom, $urandom};
    clr_req = allow_clr && ($urandom_range(0, 15) == 0);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, clr_done} !== 2'b00 || rdata !== '0) begin errors++; $display("FAIL reset_init busy=%b done=%b rdata=%h exp 0", busy, clr_done, rdata); end
    reset = 1'b0;
    repeat (6) begin rand_inputs(0); tick(); end
    we = '0; clr_req = 1'b1; tick();
    clr_req = 1'b0; tick(); tick();
    #2 reset = 1'b1;
    #1 model_reset();
    checks++; if (busy !== 1'b0 || clr_done !== 1'b0 || rdata !== '0) begin errors++; $display("FAIL reset_async busy=%b done=%b rdata=%h exp 0", busy, clr_done, rdata); end
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < D; k += NR) begin
      raddr = {AW'(k+3), AW'(k+2), AW'(k+1), AW'(k)};
      tick();
      checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_read base %0d got %h exp 0", k, rdata); end
    end
  endtask

  task automatic test_priority();
    we = 2'b11; waddr = {4'd5, 4'd5}; wdata = {32'h5555, 32'hAAAA};
    raddr = {4'd7, 4'd5, 4'd9, 4'd5};
    tick();
    checks++; if (rdata[DW-1:0] !== 32'h5555) begin errors++; $display("FAIL prio_fwd got %h exp 00005555", rdata[DW-1:0]); end
    for (int i = 0; i < NR; i++) begin
      checks++; if (rdata[i*DW +: DW] !== exp_rd[i]) begin errors++; $display("FAIL prio_port%0d got %h exp %h", i, rdata[i*DW +: DW], exp_rd[i]); end
    end
    we = '0; raddr = {4{4'd5}};
    tick();
    checks++; if (rdata !== {4{32'h5555}}) begin errors++; $display("FAIL prio_stored got %h exp 4x00005555", rdata); end
  endtask

  task automatic test_clear();
    for (int a = 0; a < D; a += 2) begin
      we = 2'b11; waddr = {AW'(a+1), AW'(a)}; wdata = {2{32'hFFFF_FFFF}};
      tick();
    end
    we = '0; clr_req = 1'b1; raddr = NR*AW'($urandom);
    tick();
    for (int c = 1; c <= D; c++) begin
      checks++; if (busy !== 1'b1 || clr_done !== 1'b0) begin errors++; $display("FAIL clr_busy cycle T+%0d busy=%b done=%b exp 1/0", c, busy, clr_done); end
      for (int i = 0; i < NR; i++) begin
        checks++; if (rdata[i*DW +: DW] !== exp_rd[i]) begin errors++; $display("FAIL clr_read T+%0d port%0d got %h exp %h", c, i, rdata[i*DW +: DW], exp_rd[i]); end
      end
      rand_inputs(1);
      tick();
    end
    checks++; if (busy !== 1'b0 || clr_done !== 1'b1) begin errors++; $display("FAIL clr_done busy=%b done=%b exp 0/1", busy, clr_done); end
    we = '0; clr_req = 1'b0;
    for (int k = 0; k < D; k += NR) begin
      raddr = {AW'(k+3), AW'(k+2), AW'(k+1), AW'(k)};
      tick();
      checks++; if (rdata !== '0 || clr_done !== 1'b0) begin errors++; $display("FAIL clr_after base %0d got %h done=%b exp 0", k, rdata, clr_done); end
    end
  endtask

  task automatic test_back_to_back();
    we = '0; clr_req = 1'b1; tick();
    repeat (D-1) begin rand_inputs(1); tick(); end
    clr_req = 1'b0; we = '0; tick();
    checks++; if (clr_done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b exp 1", clr_done); end
    clr_req = 1'b1; tick();
    checks++; if (busy !== 1'b1 || clr_done !== 1'b0) begin errors++; $display("FAIL b2b_accept busy=%b done=%b exp 1/0", busy, clr_done); end
    clr_req = 1'b0;
    repeat (D) begin
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL b2b_busy got %b exp %b", busy, m_busy); end
      tick();
    end
    checks++; if (clr_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_done2 done=%b busy=%b exp 1/0", clr_done, busy); end
  endtask

  task automatic test_reset_mid_clear();
    repeat (8) begin rand_inputs(0); tick(); end
    we = '0; clr_req = 1'b1; tick();
    clr_req = 1'b0;
    repeat (6) tick();
    #2 reset = 1'b1;
    #1 model_reset();
    checks++; if (busy !== 1'b0 || rdata !== '0) begin errors++; $display("FAIL midclr_reset busy=%b rdata=%h exp 0", busy, rdata); end
    @(negedge clk) reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      we = '0; raddr = {AW'(c*4+3), AW'(c*4+2), AW'(c*4+1), AW'(c*4)};
      tick();
      checks++; if (clr_done !== 1'b0 || busy !== 1'b0 || rdata !== '0) begin errors++; $display("FAIL midclr_idle c%0d done=%b busy=%b rdata=%h exp 0", c, clr_done, busy, rdata); end
    end
  endtask

  task automatic test_independent();
    we = 2'b01; waddr = {4'd0, 4'd1}; wdata = {32'h0, 32'h11};
    tick();
    raddr = {4'd1, 4'd3, 4'd2, 4'd1};
    we = 2'b11; waddr = {4'd3, 4'd2}; wdata = {32'h34, 32'h12};
    tick();
    checks++; if (rdata !== {32'h11, 32'h34, 32'h12, 32'h11}) begin errors++; $display("FAIL indep got %h exp 00000011_00000034_00000012_00000011", rdata); end
    we = '0; tick();
  endtask

  task automatic test_zero_reg();
    logic [DW-1:0] want;
    want = ZR ? 32'h0 : 32'hDEAD;
    we = 2'b01; waddr = '0; wdata = {32'h0, 32'hDEAD}; raddr = '0;
    tick();
    checks++; if (rdata[DW-1:0] !== want) begin errors++; $display("FAIL zero_fwd got %h exp %h", rdata[DW-1:0], want); end
    we = '0; tick();
    checks++; if (rdata !== {4{want}}) begin errors++; $display("FAIL zero_read got %h exp 4x%h", rdata, want); end
  endtask

  task automatic test_random();
    repeat (400) begin
      rand_inputs(1);
      tick();
      checks++; if (busy !== m_busy || clr_done !== m_done) begin errors++; $display("FAIL rnd_status busy=%b done=%b exp %b/%b", busy, clr_done, m_busy, m_done); end
      for (int i = 0; i < NR; i++) begin
        checks++; if (rdata[i*DW +: DW] !== exp_rd[i]) begin errors++; $display("FAIL rnd_port%0d got %h exp %h", i, rdata[i*DW +: DW], exp_rd[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_clear();
    test_back_to_back();
    test_reset_mid_clear();
    test_independent();
    test_zero_reg();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
